// File: rtl/ps2_host_tx.sv
// Host-to-device PS/2 transmitter: inhibits the bus, issues a request-to-send,
// then shifts one command byte out on device clock edges and checks the ack.
module ps2_host_tx #(
  parameter int unsigned INHIBIT_CYCLES = 10000,
  parameter int unsigned SETUP_CYCLES   = 200,
  parameter int unsigned TIMEOUT_CYCLES = 2000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  input  logic       ps2_clk_i,
  input  logic       ps2_data_i,
  output logic       ps2_clk_oe,
  output logic       ps2_data_oe,
  output logic       busy,
  output logic       done,
  output logic [1:0] err
);

  localparam int unsigned PH_MAX = (INHIBIT_CYCLES > SETUP_CYCLES) ? INHIBIT_CYCLES : SETUP_CYCLES;
  localparam int unsigned PH_W   = $clog2(PH_MAX) + 1;
  localparam int unsigned TMO_W  = $clog2(TIMEOUT_CYCLES) + 1;
  localparam int unsigned BIT_W  = 4;

  localparam logic [1:0] ERR_OK      = 2'b00;
  localparam logic [1:0] ERR_NOACK   = 2'b01;
  localparam logic [1:0] ERR_TIMEOUT = 2'b10;

  localparam logic [PH_W-1:0]  INHIBIT_LAST = PH_W'(INHIBIT_CYCLES - 1);
  localparam logic [PH_W-1:0]  SETUP_LAST   = PH_W'(SETUP_CYCLES - 1);
  localparam logic [TMO_W-1:0] TMO_LIMIT    = TMO_W'(TIMEOUT_CYCLES);

  typedef enum logic [2:0] {
    IDLE,
    INHIBIT,
    START,
    SHIFT,
    ACK,
    WAIT_IDLE
  } state_t;

  state_t            state_q, state_d;
  logic [PH_W-1:0]   ph_cnt_q, ph_cnt_d;
  logic [TMO_W-1:0]  tmo_q, tmo_d, tmo_inc;
  logic [BIT_W-1:0]  n_q, n_d;
  logic [7:0]        byte_q, byte_d;
  logic              par_q, par_d;
  logic              nack_q, nack_d;
  logic              clk_oe_d, data_oe_d, busy_d, done_d, ready_d;
  logic [1:0]        err_d;
  logic              tmo_hit;

  // Two-flop synchronizers; clk_prev gives the falling-edge reference
  logic clk_meta, clk_sync, clk_prev;
  logic data_meta, data_sync;
  logic clk_fe;

  assign clk_fe  = clk_prev & ~clk_sync;
  assign tmo_inc = (tmo_q == TMO_LIMIT) ? tmo_q : tmo_q + TMO_W'(1);
  assign tmo_hit = (tmo_inc == TMO_LIMIT);

  always_ff @(posedge clk) begin
    if (rst) begin
      clk_meta  <= 1'b1;
      clk_sync  <= 1'b1;
      clk_prev  <= 1'b1;
      data_meta <= 1'b1;
      data_sync <= 1'b1;
    end else begin
      clk_meta  <= ps2_clk_i;
      clk_sync  <= clk_meta;
      clk_prev  <= clk_sync;
      data_meta <= ps2_data_i;
      data_sync <= data_meta;
    end
  end

  // State and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      ph_cnt_q    <= '0;
      tmo_q       <= '0;
      n_q         <= '0;
      byte_q      <= '0;
      par_q       <= 1'b0;
      nack_q      <= 1'b0;
      ps2_clk_oe  <= 1'b0;
      ps2_data_oe <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      err         <= ERR_OK;
      tx_ready    <= 1'b1;
    end else begin
      state_q     <= state_d;
      ph_cnt_q    <= ph_cnt_d;
      tmo_q       <= tmo_d;
      n_q         <= n_d;
      byte_q      <= byte_d;
      par_q       <= par_d;
      nack_q      <= nack_d;
      ps2_clk_oe  <= clk_oe_d;
      ps2_data_oe <= data_oe_d;
      busy        <= busy_d;
      done        <= done_d;
      err         <= err_d;
      tx_ready    <= ready_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    ph_cnt_d  = ph_cnt_q;
    tmo_d     = tmo_q;
    n_d       = n_q;
    byte_d    = byte_q;
    par_d     = par_q;
    nack_d    = nack_q;
    clk_oe_d  = ps2_clk_oe;
    data_oe_d = ps2_data_oe;
    done_d    = 1'b0;
    err_d     = err;

    case (state_q)
      IDLE: begin
        if (tx_valid && tx_ready) begin
          byte_d    = tx_data;
          par_d     = ~^tx_data;
          nack_d    = 1'b0;
          err_d     = ERR_OK;
          ph_cnt_d  = '0;
          clk_oe_d  = 1'b1;
          data_oe_d = 1'b0;
          state_d   = INHIBIT;
        end
      end

      INHIBIT: begin
        if (ph_cnt_q == INHIBIT_LAST) begin
          ph_cnt_d  = '0;
          data_oe_d = 1'b1;
          state_d   = START;
        end else begin
          ph_cnt_d = ph_cnt_q + PH_W'(1);
        end
      end

      START: begin
        if (ph_cnt_q == SETUP_LAST) begin
          ph_cnt_d = '0;
          clk_oe_d = 1'b0;
          n_d      = '0;
          tmo_d    = '0;
          state_d  = SHIFT;
        end else begin
          ph_cnt_d = ph_cnt_q + PH_W'(1);
        end
      end

      // n_q counts falling edges already handled; edge n_q+1 drives the next bit
      SHIFT: begin
        if (clk_fe) begin
          n_d = n_q + BIT_W'(1);
          if (n_q < BIT_W'(8)) begin
            data_oe_d = ~byte_q[n_q[2:0]];
          end else if (n_q == BIT_W'(8)) begin
            data_oe_d = ~par_q;
          end else begin
            data_oe_d = 1'b0;
            state_d   = ACK;
          end
        end
      end

      ACK: begin
        if (clk_fe) begin
          nack_d  = data_sync;
          state_d = WAIT_IDLE;
        end
      end

      WAIT_IDLE: begin
        if (clk_sync && data_sync) begin
          done_d  = 1'b1;
          err_d   = nack_q ? ERR_NOACK : ERR_OK;
          state_d = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase

    // Timeout overrides whatever the bit phase decided this cycle
    if (state_q inside {SHIFT, ACK, WAIT_IDLE}) begin
      tmo_d = tmo_inc;
      if (tmo_hit) begin
        clk_oe_d  = 1'b0;
        data_oe_d = 1'b0;
        done_d    = 1'b1;
        err_d     = ERR_TIMEOUT;
        state_d   = IDLE;
      end
    end

    busy_d  = (state_d != IDLE);
    ready_d = (state_d == IDLE) && !done_d;
  end

endmodule

// File: tb/tb_ps2_host_tx.sv
// Directed bench for ps2_host_tx with a behavioural PS/2 device on the
// wired-AND bus lines.
module tb_ps2_host_tx;

  localparam int unsigned INH  = 20;
  localparam int unsigned SET  = 4;
  localparam int unsigned TMO  = 5000;
  localparam int          HALF = 50;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] tx_data = 8'h00;
  logic       tx_valid = 1'b0;
  logic       tx_ready;
  logic       ps2_clk_i, ps2_data_i;
  logic       ps2_clk_oe, ps2_data_oe;
  logic       busy, done;
  logic [1:0] err;

  logic dev_clk  = 1'b1;
  logic dev_data = 1'b1;

  int checks = 0;
  int errors = 0;
  int done_pulses = 0;

  assign ps2_clk_i  = dev_clk & ~ps2_clk_oe;
  assign ps2_data_i = dev_data & ~ps2_data_oe;

  always #5 clk = ~clk;

  always @(negedge clk) if (done === 1'b1) done_pulses <= done_pulses + 1;

  ps2_host_tx #(
    .INHIBIT_CYCLES(INH),
    .SETUP_CYCLES  (SET),
    .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .tx_data    (tx_data),
    .tx_valid   (tx_valid),
    .tx_ready   (tx_ready),
    .ps2_clk_i  (ps2_clk_i),
    .ps2_data_i (ps2_data_i),
    .ps2_clk_oe (ps2_clk_oe),
    .ps2_data_oe(ps2_data_oe),
    .busy       (busy),
    .done       (done),
    .err        (err)
  );

  task automatic start_req(input logic [7:0] b);
    @(negedge clk);
    tx_data  = b;
    tx_valid = 1'b1;
    @(negedge clk);
    tx_valid = 1'b0;
  endtask

  // Counts cycles with clk_oe held; first = cycle index where data_oe rises
  task automatic request_phase(output int k, output int first);
    k = 0;
    first = -1;
    while (ps2_clk_oe === 1'b1 && k < 200) begin
      if (ps2_data_oe === 1'b1 && first < 0) first = k;
      k++;
      @(negedge clk);
    end
  endtask

  // Device clocks ten bits, sampling the data line on each rising edge
  task automatic dev_frame(output logic start_bit, output logic [9:0] bits);
    repeat (HALF) @(negedge clk);
    start_bit = ps2_data_i;
    for (int i = 0; i < 10; i++) begin
      dev_clk = 1'b0;
      repeat (HALF) @(negedge clk);
      dev_clk = 1'b1;
      bits[i] = ps2_data_i;
      repeat (HALF) @(negedge clk);
    end
  endtask

  task automatic dev_ack(input bit pull);
    if (pull) dev_data = 1'b0;
    repeat (HALF / 2) @(negedge clk);
    dev_clk = 1'b0;
    repeat (HALF) @(negedge clk);
    dev_clk  = 1'b1;
    dev_data = 1'b1;
  endtask

  task automatic wait_done(input int max, output bit seen, output logic [1:0] e);
    seen = 1'b0;
    e = 2'bxx;
    for (int i = 0; i < max && !seen; i++) begin
      if (done === 1'b1) begin
        seen = 1'b1;
        e = err;
      end else begin
        @(negedge clk);
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if (ps2_clk_oe !== 1'b0) begin errors++; $display("FAIL rst_clk_oe: got %b want 0", ps2_clk_oe); end
    checks++; if (ps2_data_oe !== 1'b0) begin errors++; $display("FAIL rst_data_oe: got %b want 0", ps2_data_oe); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b want 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL rst_done: got %b want 0", done); end
    checks++; if (err !== 2'b00) begin errors++; $display("FAIL rst_err: got %b want 00", err); end
    checks++; if (tx_ready !== 1'b1) begin errors++; $display("FAIL rst_ready: got %b want 1", tx_ready); end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_ack_f4();
    int k, first, p0;
    logic sb;
    logic [9:0] bits;
    bit seen;
    logic [1:0] e;
    p0 = done_pulses;
    start_req(8'hF4);
    checks++; if (busy !== 1'b1 || tx_ready !== 1'b0) begin errors++; $display("FAIL f4_accept: busy=%b ready=%b want 1/0", busy, tx_ready); end
    request_phase(k, first);
    checks++; if (k !== 24) begin errors++; $display("FAIL f4_clk_oe_len: got %0d want 24", k); end
    checks++; if (first !== 20) begin errors++; $display("FAIL f4_data_oe_start: got %0d want 20", first); end
    checks++; if (ps2_data_oe !== 1'b1) begin errors++; $display("FAIL f4_start_hold: got %b want 1", ps2_data_oe); end
    dev_frame(sb, bits);
    checks++; if (sb !== 1'b0) begin errors++; $display("FAIL f4_start_bit: got %b want 0", sb); end
    checks++; if (bits[7:0] !== 8'hF4) begin errors++; $display("FAIL f4_data: got %h want f4", bits[7:0]); end
    // 0xF4 has five ones, so odd parity is 0
    checks++; if (bits[8] !== 1'b0) begin errors++; $display("FAIL f4_parity: got %b want 0", bits[8]); end
    checks++; if (bits[9] !== 1'b1) begin errors++; $display("FAIL f4_stop: got %b want 1", bits[9]); end
    dev_ack(1'b1);
    wait_done(50, seen, e);
    checks++; if (!seen) begin errors++; $display("FAIL f4_done: got none want pulse"); end
    checks++; if (e !== 2'b00) begin errors++; $display("FAIL f4_err: got %b want 00", e); end
    @(negedge clk);
    checks++; if (tx_ready !== 1'b1 || busy !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL f4_idle: ready=%b busy=%b done=%b want 1/0/0", tx_ready, busy, done); end
    repeat (5) @(negedge clk);
    checks++; if (done_pulses - p0 !== 1) begin errors++; $display("FAIL f4_done_count: got %0d want 1", done_pulses - p0); end
  endtask

  task automatic test_no_ack_ff();
    int k, first;
    logic sb;
    logic [9:0] bits;
    bit seen;
    logic [1:0] e;
    start_req(8'hFF);
    request_phase(k, first);
    dev_frame(sb, bits);
    checks++; if (bits[7:0] !== 8'hFF) begin errors++; $display("FAIL ff_data: got %h want ff", bits[7:0]); end
    checks++; if (bits[8] !== 1'b1) begin errors++; $display("FAIL ff_parity: got %b want 1", bits[8]); end
    dev_ack(1'b0);
    wait_done(50, seen, e);
    checks++; if (!seen) begin errors++; $display("FAIL ff_done: got none want pulse"); end
    checks++; if (e !== 2'b01) begin errors++; $display("FAIL ff_err: got %b want 01", e); end
  endtask

  task automatic test_timeout();
    int k, first;
    start_req(8'hF4);
    request_phase(k, first);
    checks++; if (k !== 24) begin errors++; $display("FAIL tmo_clk_oe_len: got %0d want 24", k); end
    repeat (TMO - 1) @(negedge clk);
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL tmo_early: got done=%b want 0", done); end
    @(negedge clk);
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL tmo_done: got %b want 1", done); end
    checks++; if (err !== 2'b10) begin errors++; $display("FAIL tmo_err: got %b want 10", err); end
    checks++; if (ps2_clk_oe !== 1'b0 || ps2_data_oe !== 1'b0) begin errors++; $display("FAIL tmo_release: clk_oe=%b data_oe=%b want 0/0", ps2_clk_oe, ps2_data_oe); end
    repeat (3) @(negedge clk);
  endtask

  task automatic test_back_to_back();
    int k, first, p0;
    logic sb;
    logic [9:0] bits;
    bit seen;
    logic [1:0] e;
    p0 = done_pulses;
    @(negedge clk);
    tx_data  = 8'h11;
    tx_valid = 1'b1;
    @(negedge clk);
    tx_data = 8'h22;
    request_phase(k, first);
    dev_frame(sb, bits);
    checks++; if (bits[7:0] !== 8'h11) begin errors++; $display("FAIL b2b_first: got %h want 11", bits[7:0]); end
    dev_ack(1'b1);
    wait_done(50, seen, e);
    checks++; if (!seen || e !== 2'b00) begin errors++; $display("FAIL b2b_done1: seen=%b err=%b want 1/00", seen, e); end
    @(negedge clk);
    checks++; if (busy !== 1'b0 || tx_ready !== 1'b1) begin errors++; $display("FAIL b2b_gap: busy=%b ready=%b want 0/1", busy, tx_ready); end
    @(negedge clk);
    checks++; if (busy !== 1'b1 || ps2_clk_oe !== 1'b1) begin errors++; $display("FAIL b2b_reaccept: busy=%b clk_oe=%b want 1/1", busy, ps2_clk_oe); end
    tx_valid = 1'b0;
    request_phase(k, first);
    checks++; if (k !== 24) begin errors++; $display("FAIL b2b_clk_oe_len: got %0d want 24", k); end
    dev_frame(sb, bits);
    checks++; if (bits[7:0] !== 8'h22 || bits[8] !== 1'b1) begin errors++; $display("FAIL b2b_second: got %h par %b want 22 par 1", bits[7:0], bits[8]); end
    dev_ack(1'b1);
    wait_done(50, seen, e);
    repeat (5) @(negedge clk);
    checks++; if (done_pulses - p0 !== 2) begin errors++; $display("FAIL b2b_done_count: got %0d want 2", done_pulses - p0); end
  endtask

  task automatic test_reset_mid();
    int k, first, p0;
    logic sb;
    logic [9:0] bits;
    bit seen;
    logic [1:0] e;
    p0 = done_pulses;
    start_req(8'h5A);
    request_phase(k, first);
    repeat (HALF) @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      dev_clk = 1'b0;
      repeat (HALF) @(negedge clk);
      if (i < 4) begin
        dev_clk = 1'b1;
        repeat (HALF) @(negedge clk);
      end
    end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL rm_busy_before: got %b want 1", busy); end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++; if (ps2_clk_oe !== 1'b0 || ps2_data_oe !== 1'b0) begin errors++; $display("FAIL rm_release: clk_oe=%b data_oe=%b want 0/0", ps2_clk_oe, ps2_data_oe); end
    checks++; if (busy !== 1'b0 || done !== 1'b0 || tx_ready !== 1'b1) begin errors++; $display("FAIL rm_idle: busy=%b done=%b ready=%b want 0/0/1", busy, done, tx_ready); end
    dev_clk = 1'b1;
    repeat (30) @(negedge clk);
    checks++; if (done_pulses !== p0) begin errors++; $display("FAIL rm_no_done: got %0d pulses want 0", done_pulses - p0); end
    start_req(8'hF3);
    request_phase(k, first);
    dev_frame(sb, bits);
    checks++; if (bits[7:0] !== 8'hF3 || bits[8] !== 1'b1) begin errors++; $display("FAIL rm_f3_bits: got %h par %b want f3 par 1", bits[7:0], bits[8]); end
    dev_ack(1'b1);
    wait_done(50, seen, e);
    checks++; if (!seen || e !== 2'b00) begin errors++; $display("FAIL rm_f3_done: seen=%b err=%b want 1/00", seen, e); end
  endtask

  initial begin
    test_reset();
    test_ack_f4();
    test_no_ack_ff();
    test_timeout();
    test_back_to_back();
    test_reset_mid();
    repeat (5) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
